// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared types and constants for the two-requester ALU arbiter.
//   DATA_W      : operand / result width
//   alu_op_t    : operation codes carried on reqN_op
//   arb_state_t : arbiter FSM states
package alu_arbiter_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu4_core.sv
// alu4_core
// Purely combinational 4-bit ALU shared by both requesters.
// Ports:
//   a, b   : operands (DATA_W bits)
//   op     : operation code (see alu_op_t)
//   result : low DATA_W bits of the operation
//   carry  : carry out for ADD, borrow for SUB, 0 for logic ops
//   zero   : set when result is all zeros
module alu4_core
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] wide;

  // One extra bit on the arithmetic ops: the top bit is the carry for ADD
  // and goes high as a borrow for SUB when a < b.
  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_XOR:  wide = {1'b0, a ^ b};
      default: wide = '0;
    endcase
  end

  assign result = wide[DATA_W-1:0];
  assign carry  = wide[DATA_W];
  assign zero   = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Arbitrates two requesters onto one shared ALU. A request is accepted in
// IDLE (reqN_ready is combinational), computed in EXEC and presented in
// RESP until the consumer takes it.
// Parameter:
//   FIXED_PRIO : 0 = round-robin on ties, 1 = requester 0 always wins ties
// Ports:
//   clock, reset (async, active-low)
//   req0_*/req1_* : valid/ready handshake plus a, b, op per requester
//   rsp_*         : valid/ready response with id, result, carry, zero
//   busy          : FSM is not in IDLE
//   grant_cnt0/1  : accepted-operation counters
// Optional feature:
//   ALU_ARBITER_STATS_EN : when defined, grant_cnt0/1 count accepts
//                          (wrapping); otherwise they are tied to 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req0_op,
  input  logic [1:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              busy,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1
);

  arb_state_t        state;
  logic              last_grant;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;
  logic [1:0]        lat_op;
  logic              lat_id;

  logic              grant_any;
  logic              grant_id;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [1:0]        sel_op;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  // Grant decision, only meaningful in IDLE. On a tie the round-robin
  // pointer favours whoever was not granted last.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = FIXED_PRIO ? 1'b0 : ~last_grant;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any &&  grant_id;

  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;
  assign sel_op = grant_id ? req1_op : req0_op;

  alu4_core u_alu (
    .a      (lat_a),
    .b      (lat_b),
    .op     (lat_op),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Main FSM. Response fields are only written in EXEC so they stay frozen
  // for the whole RESP stall. The last-grant pointer resets to 1 so that
  // requester 0 wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      lat_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            lat_a      <= sel_a;
            lat_b      <= sel_b;
            lat_op     <= sel_op;
            lat_id     <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_zero   <= alu_zero;
          rsp_id     <= lat_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;

  // Accept counters; plain 8-bit wrap is intended.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else begin
      if (req0_valid && req0_ready) cnt0 <= cnt0 + 8'd1;
      if (req1_valid && req1_ready) cnt1 <= cnt1 + 8'd1;
    end
  end

  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
`else
  assign grant_cnt0 = 8'd0;
  assign grant_cnt1 = 8'd0;
`endif

endmodule
